// File: rtl/player_action_ctrl.sv
// Player action controller: turns the keyboard keycode into frame-paced
// movement levels, a one-shot jump request and a windup/active/recover
// attack sequence. All key and FSM updates happen only on frame ticks.
module player_action_ctrl #(
   parameter logic [7:0] KEY_LEFT       = 8'h04,
   parameter logic [7:0] KEY_RIGHT      = 8'h07,
   parameter logic [7:0] KEY_JUMP       = 8'h1A,
   parameter logic [7:0] KEY_ATTACK     = 8'h0D,
   parameter int         WINDUP_FRAMES  = 4,
   parameter int         ACTIVE_FRAMES  = 6,
   parameter int         RECOVER_FRAMES = 10
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Soft_Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   output logic       frame_tick,
   output logic       move_left,
   output logic       move_right,
   output logic       jump_pulse,
   output logic [1:0] attack_state,
   output logic       attack_active
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WINDUP  = 2'd1,
      ACTIVE  = 2'd2,
      RECOVER = 2'd3
   } atk_t;

   logic       rst;
   logic       fclk_s1, fclk_s2, fclk_hist;
   atk_t       state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] key_q, key_q_nxt;
   logic [7:0] key_prev, key_prev_nxt;
   logic       left_nxt, right_nxt, jump_nxt, active_nxt;
   logic       atk_press;

   assign rst          = Reset | Soft_Reset;
   assign attack_state = state;

   // Synchronizer plus history flop. frame_tick is registered one stage
   // early (s1 & ~s2) so it always equals s2 & ~hist without a gate
   // on the output path.
   always_ff @(posedge Clk) begin
      if (rst) begin
         fclk_s1    <= 1'b0;
         fclk_s2    <= 1'b0;
         fclk_hist  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         fclk_s1    <= frame_clk;
         fclk_s2    <= fclk_s1;
         fclk_hist  <= fclk_s2;
         frame_tick <= fclk_s1 & ~fclk_s2;
      end
   end

   // State, counter, key history and registered outputs; reset beats a tick.
   always_ff @(posedge Clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         key_q         <= 8'h00;
         key_prev      <= 8'h00;
         move_left     <= 1'b0;
         move_right    <= 1'b0;
         jump_pulse    <= 1'b0;
         attack_active <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         key_q         <= key_q_nxt;
         key_prev      <= key_prev_nxt;
         move_left     <= left_nxt;
         move_right    <= right_nxt;
         jump_pulse    <= jump_nxt;
         attack_active <= active_nxt;
      end
   end

   // Next-state: key sampling, attack sequencing and output decode.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      key_q_nxt    = key_q;
      key_prev_nxt = key_prev;
      jump_nxt     = 1'b0;
      atk_press    = 1'b0;

      if (frame_tick) begin
         key_q_nxt    = keycode;
         key_prev_nxt = key_q;
         // Edge detection compares the new key against the key it replaces.
         atk_press    = (keycode == KEY_ATTACK) && (key_q != KEY_ATTACK);
         jump_nxt     = (keycode == KEY_JUMP) && (key_q != KEY_JUMP) &&
                        (state == IDLE);
         case (state)
            IDLE: begin
               if (atk_press) begin
                  state_nxt = WINDUP;
                  cnt_nxt   = 4'(WINDUP_FRAMES - 1);
               end
            end
            WINDUP: begin
               if (cnt == 4'd0) begin
                  state_nxt = ACTIVE;
                  cnt_nxt   = 4'(ACTIVE_FRAMES - 1);
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
            ACTIVE: begin
               if (cnt == 4'd0) begin
                  state_nxt = RECOVER;
                  cnt_nxt   = 4'(RECOVER_FRAMES - 1);
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
            RECOVER: begin
               if (cnt == 4'd0) begin
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      // Movement is only granted while idle; KEY_LEFT != KEY_RIGHT keeps
      // the two levels mutually exclusive.
      left_nxt   = (key_q_nxt == KEY_LEFT)  && (state_nxt == IDLE);
      right_nxt  = (key_q_nxt == KEY_RIGHT) && (state_nxt == IDLE);
      active_nxt = (state_nxt == ACTIVE);
   end

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed bench for player_action_ctrl: each frame pushes the expected
// post-tick outputs to a queue; a monitor pops and compares them on the
// cycle after every frame_tick.
module tb_player_action_ctrl;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Soft_Reset = 1'b0;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       frame_tick, move_left, move_right, jump_pulse, attack_active;
   logic [1:0] attack_state;

   player_action_ctrl dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Soft_Reset    (Soft_Reset),
      .frame_clk     (frame_clk),
      .keycode       (keycode),
      .frame_tick    (frame_tick),
      .move_left     (move_left),
      .move_right    (move_right),
      .jump_pulse    (jump_pulse),
      .attack_state  (attack_state),
      .attack_active (attack_active)
   );

   always #10 Clk = ~Clk;

   typedef struct {
      logic [1:0] st;
      logic       act, l, r, j;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic no_model = 1'b0;
   logic post = 1'b0;

   // reference model state
   logic [1:0] m_st  = 2'd0;
   logic [3:0] m_cnt = 4'd0;
   logic [7:0] m_key = 8'h00;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_frame(input logic [7:0] k);
      exp_t       e;
      logic [7:0] prev;
      logic       was_idle;
      prev     = m_key;
      m_key    = k;
      was_idle = (m_st == 2'd0);
      case (m_st)
         2'd0: if (k == 8'h0D && prev != 8'h0D) begin m_st = 2'd1; m_cnt = 4'd3; end
         2'd1: if (m_cnt == 0) begin m_st = 2'd2; m_cnt = 4'd5; end else m_cnt--;
         2'd2: if (m_cnt == 0) begin m_st = 2'd3; m_cnt = 4'd9; end else m_cnt--;
         default: if (m_cnt == 0) m_st = 2'd0; else m_cnt--;
      endcase
      e.st  = m_st;
      e.act = (m_st == 2'd2);
      e.l   = (k == 8'h04) && (m_st == 2'd0);
      e.r   = (k == 8'h07) && (m_st == 2'd0);
      e.j   = (k == 8'h1A) && (prev != 8'h1A) && was_idle;
      q.push_back(e);
   endtask

   task automatic do_frame(input logic [7:0] k);
      @(negedge Clk);
      keycode = k;
      model_frame(k);
      repeat (2) @(negedge Clk);
      frame_clk = 1'b1;
      repeat (8) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (8) @(negedge Clk);
   endtask

   // Monitor: compare outputs on the cycle after each tick; jump must be low elsewhere.
   always @(negedge Clk) begin
      if (post) begin
         post = 1'b0;
         if (q.size() == 0) begin
            chk("unexpected_tick", 8'd1, 8'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("attack_state", {6'd0, attack_state}, {6'd0, e.st});
            chk("attack_active", {7'd0, attack_active}, {7'd0, e.act});
            chk("move_left", {7'd0, move_left}, {7'd0, e.l});
            chk("move_right", {7'd0, move_right}, {7'd0, e.r});
            chk("jump_pulse", {7'd0, jump_pulse}, {7'd0, e.j});
         end
      end else if (!Reset && !Soft_Reset) begin
         chk("jump_idle_low", {7'd0, jump_pulse}, 8'd0);
      end
      if (frame_tick && !no_model) post = 1'b1;
   end

   initial begin
      // reset state
      repeat (3) @(negedge Clk);
      chk("rst_state", {6'd0, attack_state}, 8'd0);
      chk("rst_active", {7'd0, attack_active}, 8'd0);
      chk("rst_left", {7'd0, move_left}, 8'd0);
      chk("rst_right", {7'd0, move_right}, 8'd0);
      chk("rst_tick", {7'd0, frame_tick}, 8'd0);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);

      // held left for 3 frames
      repeat (3) do_frame(8'h04);
      do_frame(8'h00);

      // held jump for 5 frames: a single pulse
      repeat (5) do_frame(8'h1A);
      do_frame(8'h00);

      // attack tap, then right pressed during ACTIVE and held to past IDLE
      do_frame(8'h0D);
      repeat (5) do_frame(8'h00);
      repeat (18) do_frame(8'h07);
      do_frame(8'h00);

      // keycode chatter with frame_clk low: nothing moves
      for (int i = 0; i < 12; i++) begin
         @(negedge Clk);
         keycode = i[0] ? 8'h0D : 8'h00;
         chk("quiet_tick", {7'd0, frame_tick}, 8'd0);
         chk("quiet_state", {6'd0, attack_state}, 8'd0);
      end
      keycode = 8'h00;

      // attack into ACTIVE, then Soft_Reset coincident with a tick
      do_frame(8'h0D);
      repeat (4) do_frame(8'h00);
      @(negedge Clk);
      chk("pre_sr_state", {6'd0, attack_state}, 8'd2);
      no_model = 1'b1;
      frame_clk = 1'b1;
      for (int i = 0; i < 20 && !frame_tick; i++) @(negedge Clk);
      chk("sr_tick_seen", {7'd0, frame_tick}, 8'd1);
      Soft_Reset = 1'b1;
      @(negedge Clk);
      Soft_Reset = 1'b0;
      chk("sr_state", {6'd0, attack_state}, 8'd0);
      chk("sr_active", {7'd0, attack_active}, 8'd0);
      chk("sr_left", {7'd0, move_left}, 8'd0);
      chk("sr_right", {7'd0, move_right}, 8'd0);
      chk("sr_jump", {7'd0, jump_pulse}, 8'd0);
      repeat (6) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (8) @(negedge Clk);
      no_model = 1'b0;
      m_st = 2'd0; m_cnt = 4'd0; m_key = 8'h00;

      // attack held through the whole sequence: no re-trigger
      repeat (22) do_frame(8'h0D);
      // a few random keys from the action set
      for (int i = 0; i < 12; i++) begin
         logic [7:0] ks [5];
         ks = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h0D};
         do_frame(ks[$urandom_range(0, 4)]);
      end

      repeat (6) @(negedge Clk);
      chk("queue_drained", 8'(q.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/player_action_ctrl.md
PLAYER_ACTION_CTRL -- requirements
Module: player_action_ctrl

Interface
REQ-001 SHALL provide parameter KEY_LEFT, default 8'h04, USB HID code meaning move left.
REQ-002 SHALL provide parameter KEY_RIGHT, default 8'h07, USB HID code meaning move right.
REQ-003 SHALL provide parameter KEY_JUMP, default 8'h1A, USB HID code meaning jump.
REQ-004 SHALL provide parameter KEY_ATTACK, default 8'h0D, USB HID code meaning attack.
REQ-005 SHALL provide parameters WINDUP_FRAMES=4, ACTIVE_FRAMES=6, RECOVER_FRAMES=10, each a frame count in range 1..15.
REQ-006 SHALL have port: Clk  input  1  system clock (50 MHz); the block's one clock.
REQ-007 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port: Soft_Reset  input  1  synchronous, active-high round restart; same effect as Reset.
REQ-009 SHALL have port: frame_clk  input  1  VGA vertical sync (VGA_VS), asynchronous to Clk.
REQ-010 SHALL have port: keycode  input  8  current key from the NIOS keycode PIO; 8'h00 = no key.
REQ-011 SHALL have port: frame_tick  output  1  one-Clk pulse per frame_clk rising edge.
REQ-012 SHALL have ports: move_left, move_right  output  1 each  level movement requests.
REQ-013 SHALL have port: jump_pulse  output  1  one-Clk jump request.
REQ-014 SHALL have ports: attack_state  output  2  FSM state; attack_active  output  1  hitbox enable.

Function
REQ-015 SHALL pass frame_clk through a 2-flop synchronizer plus a third history flop; frame_tick = sync & ~history, one Clk wide.
REQ-016 SHALL register keycode into key_q only in cycles with frame_tick=1, and copy the old key_q into key_prev in the same cycle; keycode changes between ticks are ignored.
REQ-017 SHALL drive all outputs from registers; outputs reflect a tick at cycle k from cycle k+1 onward.
REQ-018 SHALL drive move_left=1 iff key_q==KEY_LEFT and attack_state==IDLE; move_right likewise with KEY_RIGHT; never both high.
REQ-019 SHALL assert jump_pulse for exactly one Clk in cycle k+1 when the tick at cycle k loads key_q==KEY_JUMP with key_prev!=KEY_JUMP and attack_state==IDLE; a held key produces no further pulses.
REQ-020 SHALL implement attack FSM, encoding IDLE=2'd0, WINDUP=2'd1, ACTIVE=2'd2, RECOVER=2'd3, with 4-bit frame counter cnt.
REQ-021 IDLE->WINDUP on a tick whose newly loaded key_q==KEY_ATTACK and key_prev!=KEY_ATTACK; cnt loads WINDUP_FRAMES-1.
REQ-022 In WINDUP/ACTIVE/RECOVER, on each tick: if cnt==0, advance (WINDUP->ACTIVE load ACTIVE_FRAMES-1, ACTIVE->RECOVER load RECOVER_FRAMES-1, RECOVER->IDLE), else cnt decrements; each state lasts exactly its parameter count of frames.
REQ-023 SHALL ignore attack presses outside IDLE (no buffering); re-attack requires release and re-press seen at a tick while IDLE.
REQ-024 SHALL drive attack_active=1 iff attack_state==ACTIVE.
REQ-025 SHALL not change FSM, cnt, or key registers in cycles without frame_tick.

Reset
REQ-026 On Reset or Soft_Reset: synchronizer/history flops, key_q, key_prev, cnt SHALL clear to 0; attack_state=IDLE; all outputs 0 the next cycle.
REQ-027 Reset or Soft_Reset asserted in the same cycle as frame_tick or mid-attack SHALL win; no tick is processed and the FSM returns to IDLE.
REQ-028 After reset release, the first frame_tick SHALL require a fresh 0->1 transition of synchronized frame_clk.

Verification
REQ-029 Hold keycode=8'h04 across 3 frame_clk edges -> move_left=1 from the cycle after the first tick, move_right=0, jump_pulse=0.
REQ-030 keycode=8'h1A held for 5 frames -> exactly one jump_pulse, one Clk wide, the cycle after the first tick.
REQ-031 keycode=8'h0D for 1 frame then 8'h00 -> attack_state 1 for 4 ticks, 2 for 6 ticks (attack_active=1), 3 for 10 ticks, then 0.
REQ-032 keycode=8'h07 pressed during ACTIVE -> move_right=0 until IDLE, then 1 on the next tick.
REQ-033 Soft_Reset pulsed during ACTIVE, coincident with frame_tick -> next cycle attack_state=0, attack_active=0, all outputs 0.
REQ-034 keycode toggled 8'h0D/8'h00 between ticks while frame_clk is held low -> no state change, frame_tick stays 0.
